// File: rtl/dmem_readback_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_readback_ctrl
//
// Reads a loader-format image back out of the datapath data memory and
// streams the payload toward the host FIFO. The image layout is: word 0
// holds the payload count N, and words 1..N hold the payload. Counts that do
// not fit in ADDR_W bits are clamped to 2**ADDR_W-1 and flagged with err.
//
// Reads are issued ahead of the consumer into a small output FIFO of depth
// RD_LAT+1. That depth covers the memory round trip, so the stream runs at
// one beat per cycle when the sink is always ready. Under backpressure the
// read issue stalls before the FIFO can overflow.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse; begins a readback when idle
//   mem_addr   data-memory read address (holds last value between strobes)
//   mem_rd_en  data-memory read strobe
//   mem_dout   data-memory read data, valid RD_LAT cycles after the strobe
//   m_data     stream payload word
//   m_valid    m_data valid
//   m_ready    downstream accepts on m_valid & m_ready
//   m_last     marks the beat read from address N
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse once the final beat has been accepted
//   count_out  latched (clamped) payload count
//   err        sticky header-overflow flag, cleared by the next start
// -----------------------------------------------------------------------------
module dmem_readback_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] count_out,
   output logic              err
);

   localparam int DEPTH = RD_LAT + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 2);
   localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W+1)'(1);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
   localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR_RD,
      HDR_WAIT,
      STREAM,
      FINISH
   } state_t;

   state_t state_q, state_d;

   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic [CW-1:0]     inflight_q, inflight_d;
   logic [CW-1:0]     occ_q, occ_d;
   logic [PW-1:0]     wrPtr_q, wrPtr_d;
   logic [PW-1:0]     rdPtr_q, rdPtr_d;
   logic [ADDR_W:0]   rdAddr_q, rdAddr_d;
   logic [ADDR_W:0]   beatCnt_q, beatCnt_d;
   logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] fifoMem_q [DEPTH];

   logic              hdrRd;
   logic              issue;
   logic              arrive;
   logic              push;
   logic              pop;
   logic              hdrOver;
   logic [ADDR_W-1:0] hdrCount;

   // Advance a FIFO pointer. The depth is RD_LAT+1, which need not be a
   // power of two, so the pointer wraps explicitly.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   // The oldest outstanding read returns when it reaches the end of the
   // latency pipe. The header is the only read in flight during HDR_WAIT,
   // so data arriving there is the count word. Data arriving during STREAM
   // is payload and goes into the FIFO.
   assign arrive   = pipe_q[RD_LAT-1];
   assign push     = arrive && (state_q == STREAM);
   assign m_valid  = (occ_q != '0);
   assign pop      = m_valid & m_ready;
   assign m_data   = m_valid ? fifoMem_q[rdPtr_q] : '0;
   assign m_last   = m_valid && (beatCnt_q == {1'b0, count_q});
   assign hdrOver  = |mem_dout[DATA_W-1:ADDR_W];
   assign hdrCount = hdrOver ? '1 : mem_dout[ADDR_W-1:0];

   assign count_out = count_q;
   assign err       = err_q;

   // State register. A reset at any point drops straight back to IDLE,
   // which abandons any readback in progress without a done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. start only matters in IDLE. The header wait ends on
   // the cycle the count word arrives. An empty image skips streaming and
   // goes directly to the done cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = HDR_RD;
            end
         end
         HDR_RD: begin
            state_d = HDR_WAIT;
         end
         HDR_WAIT: begin
            if (arrive) begin
               state_d = (hdrCount == '0) ? FINISH : STREAM;
            end
         end
         STREAM: begin
            if (pop && m_last) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs and read strobes. A payload read is issued only while the FIFO
   // plus the reads still in flight would fit after this cycle's pop. Giving
   // credit for the pop keeps a full-rate stream free of bubbles and never
   // lets returning data overrun the FIFO. The address register stops one
   // past N, so it never wraps.
   always_comb begin
      hdrRd     = 1'b0;
      issue     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = lastAddr_q;
      case (state_q)
         HDR_RD: begin
            hdrRd     = 1'b1;
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = '0;
         end
         HDR_WAIT: begin
            busy = 1'b1;
         end
         STREAM: begin
            busy = 1'b1;
            if ((rdAddr_q <= {1'b0, count_q}) &&
                ((occ_q + inflight_q) < (CW'(DEPTH) + CW'(pop)))) begin
               issue     = 1'b1;
               mem_rd_en = 1'b1;
               mem_addr  = rdAddr_q[ADDR_W-1:0];
            end
         end
         FINISH: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Datapath next-state. The latency pipe tags every strobe, including the
   // header read, so arrivals line up with mem_dout. FIFO occupancy and the
   // in-flight count each change by push/pop or issue/arrive. Simultaneous
   // push and pop leave occupancy unchanged. beatCnt numbers the beat at the
   // FIFO head, which is how m_last finds the beat from address N.
   always_comb begin
      pipe_d     = '0;
      pipe_d[0]  = mem_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      inflight_d = inflight_q + CW'(mem_rd_en) - CW'(arrive);
      occ_d      = occ_q + CW'(push) - CW'(pop);
      wrPtr_d    = push ? nextPtr(wrPtr_q) : wrPtr_q;
      rdPtr_d    = pop ? nextPtr(rdPtr_q) : rdPtr_q;
      rdAddr_d   = rdAddr_q;
      beatCnt_d  = beatCnt_q;
      lastAddr_d = mem_rd_en ? mem_addr : lastAddr_q;
      count_d    = count_q;
      err_d      = err_q;

      if ((state_q == IDLE) && start) begin
         err_d     = 1'b0;
         rdAddr_d  = ADDR_ONE;
         beatCnt_d = ADDR_ONE;
      end
      if ((state_q == HDR_WAIT) && arrive) begin
         count_d = hdrCount;
         err_d   = hdrOver;
      end
      if (issue) begin
         rdAddr_d = rdAddr_q + ADDR_ONE;
      end
      if (pop) begin
         beatCnt_d = beatCnt_q + ADDR_ONE;
      end
   end

   // Datapath registers. All of them clear on reset, so the FIFO comes back
   // empty and nothing is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_q     <= '0;
         inflight_q <= '0;
         occ_q      <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         rdAddr_q   <= '0;
         beatCnt_q  <= '0;
         lastAddr_q <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         pipe_q     <= pipe_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         rdAddr_q   <= rdAddr_d;
         beatCnt_q  <= beatCnt_d;
         lastAddr_q <= lastAddr_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   // FIFO storage. Its contents are only visible through the head pointer
   // while occupancy is nonzero, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= mem_dout;
      end
   end

endmodule

// File: tb/tb_dmem_readback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_readback_ctrl
//
// Drives two copies of dmem_readback_ctrl: one with RD_LAT=1 and one with
// RD_LAT=2. Each copy has its own latency-accurate memory model, and both
// read the same image. The model puts random junk on the read bus whenever
// no read result is due. The expected stream is taken straight from the
// image, using the clamped header count.
// -----------------------------------------------------------------------------
module tb_dmem_readback_ctrl;

   localparam int DW = 64;
   localparam int AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetN;
   logic          startTb;
   logic          mReady;
   int            sel;
   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] memImg [256];

   logic          start1, start2, rdEn1, rdEn2, valid1, valid2, last1, last2;
   logic          busy1, busy2, done1, done2, err1, err2;
   logic [AW-1:0] addr1, addr2, cnt1, cnt2;
   logic [DW-1:0] dout1, dout2, stage2, data1, data2;

   logic          mValid, mLast, mBusy, mDone, mErr, mRdEn;
   logic [AW-1:0] mAddr, mCnt;
   logic [DW-1:0] mData;

   // Only the selected copy ever sees start; the other one stays idle.
   assign start1 = startTb && (sel == 0);
   assign start2 = startTb && (sel == 1);
   assign mValid = (sel == 0) ? valid1 : valid2;
   assign mLast  = (sel == 0) ? last1  : last2;
   assign mBusy  = (sel == 0) ? busy1  : busy2;
   assign mDone  = (sel == 0) ? done1  : done2;
   assign mErr   = (sel == 0) ? err1   : err2;
   assign mRdEn  = (sel == 0) ? rdEn1  : rdEn2;
   assign mAddr  = (sel == 0) ? addr1  : addr2;
   assign mCnt   = (sel == 0) ? cnt1   : cnt2;
   assign mData  = (sel == 0) ? data1  : data2;

   dmem_readback_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u1 (
      .clk(clk), .reset_n(resetN), .start(start1),
      .mem_addr(addr1), .mem_rd_en(rdEn1), .mem_dout(dout1),
      .m_data(data1), .m_valid(valid1), .m_ready(mReady), .m_last(last1),
      .busy(busy1), .done(done1), .count_out(cnt1), .err(err1)
   );

   dmem_readback_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u2 (
      .clk(clk), .reset_n(resetN), .start(start2),
      .mem_addr(addr2), .mem_rd_en(rdEn2), .mem_dout(dout2),
      .m_data(data2), .m_valid(valid2), .m_ready(mReady), .m_last(last2),
      .busy(busy2), .done(done2), .count_out(cnt2), .err(err2)
   );

   // One-cycle-latency memory. Junk is driven whenever no read result is due.
   always @(posedge clk) begin
      dout1 <= rdEn1 ? memImg[addr1] : {$urandom, $urandom};
   end

   // Two-cycle-latency memory. Junk is driven whenever no read result is due.
   always @(posedge clk) begin
      stage2 <= rdEn2 ? memImg[addr2] : {$urandom, $urandom};
      dout2  <= stage2;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s lat=%0d: observed=%0h expected=%0h", tag, sel + 1, obs, exp);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_valid"}, 64'(mValid), 64'(0));
      checkOutput({tag, "_data"},  mData,       64'(0));
      checkOutput({tag, "_last"},  64'(mLast),  64'(0));
      checkOutput({tag, "_busy"},  64'(mBusy),  64'(0));
      checkOutput({tag, "_done"},  64'(mDone),  64'(0));
      checkOutput({tag, "_err"},   64'(mErr),   64'(0));
      checkOutput({tag, "_cnt"},   64'(mCnt),   64'(0));
      checkOutput({tag, "_rdEn"},  64'(mRdEn),  64'(0));
      checkOutput({tag, "_addr"},  64'(mAddr),  64'(0));
   endtask

   task automatic loadImage(input logic [63:0] hdr);
      memImg[0] = hdr;
      for (int i = 1; i < 256; i++) begin
         memImg[i] = {$urandom, $urandom};
      end
   endtask

   // Runs one readback and checks it against the image. mode picks the
   // ready pattern: 0 = always ready, 1 = 1,0,0,1,0,1 repeating,
   // anything else = random. restartCycle pulses start again at that cycle.
   // resetAfter > 0 pulses reset once that many beats have been accepted.
   task automatic applyStimulus(input string name, input logic [63:0] hdr, input int mode,
                                input int restartCycle, input int resetAfter);
      int          lat, expN, idx, issued, nextRd, lastAcc, doneCnt, doneCyc;
      int          firstValid, limit, outstanding;
      logic        expErr, v, l, dn, b, rdy, prevStall, prevLast, aborted;
      logic [5:0]  pat;
      logic [63:0] d, prevData;
      logic [63:0] expQ[$];

      lat     = sel + 1;
      expErr  = (hdr > 64'd255);
      expN    = expErr ? 255 : int'(hdr[7:0]);
      for (int i = 1; i <= expN; i++) begin
         expQ.push_back(memImg[i]);
      end
      idx = 0; issued = 0; nextRd = 1; lastAcc = -1; doneCnt = 0; doneCyc = -1;
      firstValid = -1; prevStall = 1'b0; prevLast = 1'b0; prevData = '0; aborted = 1'b0;
      pat   = 6'b101001;
      limit = 8 * expN + 40;
      $display("[TB] case %s lat=%0d N=%0d", name, lat, expN);

      @(negedge clk);
      startTb = 1'b1;
      mReady  = 1'b0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         @(negedge clk);
         startTb = (cyc == restartCycle);
         if (resetAfter > 0 && idx == resetAfter) begin
            startTb = 1'b0;
            mReady  = 1'b0;
            resetN  = 1'b0;
            #1;
            checkResetState("midReset");
            @(negedge clk);
            resetN  = 1'b1;
            aborted = 1'b1;
            break;
         end
         v  = mValid;
         d  = mData;
         l  = mLast;
         dn = mDone;
         b  = mBusy;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = pat[cyc % 6];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         mReady = rdy;
         #1;

         if (cyc == 1) begin
            checkOutput("hdrStrobe", 64'(mRdEn), 64'(1));
            checkOutput("hdrAddr",   64'(mAddr), 64'(0));
         end else if (issued < expN) begin
            if (mRdEn) begin
               checkOutput("rdAddr", 64'(mAddr), 64'(nextRd));
               issued++;
               nextRd++;
            end
         end else begin
            checkOutput("rdExtra", 64'(mRdEn), 64'(0));
         end

         if (prevStall) begin
            checkOutput("stallValid", 64'(v), 64'(1));
            checkOutput("stallData",  d,      prevData);
            checkOutput("stallLast",  64'(l), 64'(prevLast));
         end

         if (v) begin
            if (firstValid < 0) begin
               firstValid = cyc;
               checkOutput("firstLat", 64'(cyc), 64'(2 * lat + 3));
            end
            if (idx >= expN) begin
               checkOutput("extraBeat", 64'(v), 64'(0));
            end else if (rdy) begin
               checkOutput("data", d, expQ[idx]);
               checkOutput("last", 64'(l), 64'(idx == expN - 1));
               if (mode == 0) begin
                  checkOutput("noBubble", 64'(cyc), 64'(2 * lat + 3 + idx));
               end
               idx++;
               lastAcc = cyc;
            end
         end
         prevStall = v && !rdy;
         prevData  = d;
         prevLast  = l;

         outstanding = issued - idx;
         checkOutput("bufBound", 64'(outstanding > lat + 1), 64'(0));

         if (dn) begin
            doneCnt++;
            checkOutput("doneCycle", 64'(cyc), 64'((expN == 0) ? lat + 2 : lastAcc + 1));
            checkOutput("doneBusy",  64'(b),   64'(0));
            checkOutput("doneBeats", 64'(idx), 64'(expN));
            if (doneCyc < 0) begin
               doneCyc = cyc;
            end
         end else if (doneCyc < 0) begin
            checkOutput("busy", 64'(b), 64'(1));
         end else begin
            checkOutput("idleBusy", 64'(b), 64'(0));
         end

         if (doneCyc > 0 && cyc >= doneCyc + 3) begin
            break;
         end
      end

      if (!aborted) begin
         checkOutput("doneOnce", 64'(doneCnt), 64'(1));
         checkOutput("beats",    64'(idx),     64'(expN));
         checkOutput("count",    64'(mCnt),    64'(expN));
         checkOutput("err",      64'(mErr),    64'(expErr));
      end
      startTb = 1'b0;
      mReady  = 1'b0;
   endtask

   // Directed sequence run once per latency. It covers: full-rate and
   // throttled streams, random backpressure, an empty image, header clamp,
   // the maximum count, start ignored while busy, and reset mid-stream
   // followed by a clean restart.
   initial begin
      int n;
      resetN  = 1'b0;
      startTb = 1'b0;
      mReady  = 1'b0;
      sel     = 0;
      for (int i = 0; i < 256; i++) begin
         memImg[i] = '0;
      end
      repeat (2) @(negedge clk);
      checkResetState("resetLat1");
      sel = 1;
      #1;
      checkResetState("resetLat2");
      @(negedge clk);
      resetN = 1'b1;

      for (int s = 0; s < 2; s++) begin
         sel = s;
         loadImage(64'd3);
         memImg[1] = 64'hA1;
         memImg[2] = 64'hB2;
         memImg[3] = 64'hC3;
         applyStimulus("abcFull",   64'd3, 0, -1, 0);
         applyStimulus("abcToggle", 64'd3, 1, -1, 0);

         n = $urandom_range(1, 20);
         loadImage(64'(n));
         applyStimulus("randReady", 64'(n), 2, -1, 0);

         loadImage(64'd0);
         applyStimulus("empty", 64'd0, 0, -1, 0);

         loadImage(64'd300);
         applyStimulus("clamp", 64'd300, 0, -1, 0);

         loadImage(64'd255);
         applyStimulus("maxCount", 64'd255, 1, -1, 0);

         loadImage(64'd5);
         applyStimulus("restartIgnored", 64'd5, 1, 2 * (s + 1) + 5, 0);
         applyStimulus("resetMid",       64'd5, 0, -1, 2);
         applyStimulus("afterReset",     64'd5, 0, -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
